// File: rtl/seg_scan_driver.sv
// Multiplexed seven-segment scan driver: shows DIGITS common-cathode digits
// from one packed hex word. Data is double-buffered so a frame never mixes
// old and new values, with optional leading-zero blanking.
module seg_scan_driver #(
  parameter int DIGITS   = 4,
  parameter int SCAN_DIV = 5000,
  parameter int DIV_W    = 13
) (
  input  logic                  Sys_CLK,
  input  logic                  Sys_RST,
  input  logic                  EN,
  input  logic                  Load,
  input  logic [4*DIGITS-1:0]   Data_Hex,
  input  logic [DIGITS-1:0]     DP,
  input  logic                  Blank_Lead,
  output logic [DIGITS-1:0]     COM,
  output logic [7:0]            SEG,
  output logic                  Frame_Done
);

  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [DIV_W-1:0] LAST_DIV = DIV_W'(SCAN_DIV - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);

  logic [DIV_W-1:0]    div_cnt_q, div_cnt_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [4*DIGITS-1:0] sh_hex_q, sh_hex_d, act_hex_q, act_hex_d;
  logic [DIGITS-1:0]   sh_dp_q, sh_dp_d, act_dp_q, act_dp_d;
  logic [DIGITS-1:0]   com_q, com_d;
  logic [7:0]          seg_q, seg_d;
  logic                frame_done_q, frame_done_d;

  logic                tick;
  logic                frame_start;
  logic [DIGITS-1:0]   blank;
  logic                zero_run;
  logic [3:0]          cur_nib;
  logic                cur_dp;
  logic                cur_blank;
  logic [7:0]          seg_full;

  // Full SEG byte for a hex value with the dp bit clear.
  function automatic logic [7:0] hex_to_seg(input logic [3:0] h);
    case (h)
      4'h0: hex_to_seg = 8'hFC;
      4'h1: hex_to_seg = 8'h60;
      4'h2: hex_to_seg = 8'hDA;
      4'h3: hex_to_seg = 8'hF2;
      4'h4: hex_to_seg = 8'h66;
      4'h5: hex_to_seg = 8'hB6;
      4'h6: hex_to_seg = 8'hBE;
      4'h7: hex_to_seg = 8'hE0;
      4'h8: hex_to_seg = 8'hFE;
      4'h9: hex_to_seg = 8'hF6;
      4'hA: hex_to_seg = 8'hEE;
      4'hB: hex_to_seg = 8'h3E;
      4'hC: hex_to_seg = 8'h9C;
      4'hD: hex_to_seg = 8'h7A;
      4'hE: hex_to_seg = 8'h9E;
      default: hex_to_seg = 8'h8E;
    endcase
  endfunction

  // Next-state logic for prescaler, scan index, buffers and output registers.
  always_comb begin
    // NOTE: every signal gets a default before any branch, so no path leaves
    // a variable unassigned and no latch is inferred.
    tick         = EN && (div_cnt_q == LAST_DIV);
    frame_start  = tick && (idx_q == '0);
    div_cnt_d    = '0;
    idx_d        = '0;
    com_d        = '0;
    seg_d        = '0;
    frame_done_d = 1'b0;
    cur_nib      = '0;
    cur_dp       = 1'b0;
    cur_blank    = 1'b0;
    blank        = '0;
    zero_run     = 1'b1;

    sh_hex_d = Load ? Data_Hex : sh_hex_q;
    sh_dp_d  = Load ? DP       : sh_dp_q;

    // The frame-start edge shows digit 0 from the freshly copied shadow, so
    // the pattern below is computed from the next active value.
    act_hex_d = frame_start ? sh_hex_q : act_hex_q;
    act_dp_d  = frame_start ? sh_dp_q  : act_dp_q;

    // A digit is a leading zero when it and every higher nibble are zero.
    for (int i = DIGITS - 1; i >= 0; i--) begin
      zero_run = zero_run && (act_hex_d[i*4 +: 4] == 4'h0);
      blank[i] = Blank_Lead && zero_run && (i != 0);
    end

    for (int i = 0; i < DIGITS; i++) begin
      if (idx_q == IDX_W'(i)) begin
        cur_nib   = act_hex_d[i*4 +: 4];
        cur_dp    = act_dp_d[i];
        cur_blank = blank[i];
      end
    end
    seg_full = hex_to_seg(cur_nib);

    if (EN) begin
      div_cnt_d    = tick ? '0 : div_cnt_q + DIV_W'(1);
      idx_d        = idx_q;
      com_d        = com_q;
      seg_d        = seg_q;
      frame_done_d = tick && (idx_q == LAST_IDX);
      if (tick) begin
        idx_d = (idx_q == LAST_IDX) ? '0 : idx_q + IDX_W'(1);
        for (int i = 0; i < DIGITS; i++) begin
          com_d[i] = (idx_q == IDX_W'(i));
        end
        seg_d = {cur_blank ? 7'h00 : seg_full[7:1], cur_dp};
      end
    end
  end

  // State registers with synchronous reset; reset also clears both buffers.
  always_ff @(posedge Sys_CLK) begin
    if (Sys_RST) begin
      div_cnt_q    <= '0;
      idx_q        <= '0;
      sh_hex_q     <= '0;
      sh_dp_q      <= '0;
      act_hex_q    <= '0;
      act_dp_q     <= '0;
      com_q        <= '0;
      seg_q        <= '0;
      frame_done_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before this edge, independent of statement order.
      div_cnt_q    <= div_cnt_d;
      idx_q        <= idx_d;
      sh_hex_q     <= sh_hex_d;
      sh_dp_q      <= sh_dp_d;
      act_hex_q    <= act_hex_d;
      act_dp_q     <= act_dp_d;
      com_q        <= com_d;
      seg_q        <= seg_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign COM        = com_q;
  assign SEG        = seg_q;
  assign Frame_Done = frame_done_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Self-checking bench for seg_scan_driver: a 4-digit instance driven from a
// vector table plus directed multi-cycle sequences, and a 1-digit instance.
module tb_seg_scan_driver;

  logic        clk = 1'b0;
  logic        rst, en, load, blank_lead;
  logic [15:0] data_hex;
  logic [3:0]  dp;
  logic [3:0]  com;
  logic [7:0]  seg;
  logic        frame_done;

  logic [3:0]  data1;
  logic        dp1;
  logic        com1;
  logic [7:0]  seg1;
  logic        frame_done1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  seg_scan_driver #(.DIGITS(4), .SCAN_DIV(4), .DIV_W(3)) dut4 (
    .Sys_CLK(clk), .Sys_RST(rst), .EN(en), .Load(load),
    .Data_Hex(data_hex), .DP(dp), .Blank_Lead(blank_lead),
    .COM(com), .SEG(seg), .Frame_Done(frame_done)
  );

  seg_scan_driver #(.DIGITS(1), .SCAN_DIV(2), .DIV_W(1)) dut1 (
    .Sys_CLK(clk), .Sys_RST(rst), .EN(en), .Load(load),
    .Data_Hex(data1), .DP(dp1), .Blank_Lead(blank_lead),
    .COM(com1), .SEG(seg1), .Frame_Done(frame_done1)
  );

  typedef struct {
    logic [15:0]     hex;
    logic [3:0]      dp;
    logic            blank;
    logic [3:0][7:0] seg;   // seg[i] = expected SEG for digit i
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Advance n clock edges and settle 1 time unit past the last one.
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Reset, load one word, and step to the first frame-start edge while
  // confirming the outputs stay dark until then.
  task automatic start_run(input logic [15:0] hex, input logic [3:0] d, input logic b);
    rst = 1'b1; en = 1'b0; load = 1'b0;
    cyc(2);
    rst = 1'b0; en = 1'b1; blank_lead = b;
    data_hex = hex; dp = d; load = 1'b1;
    cyc(1);
    load = 1'b0;
    for (int k = 0; k < 3; k++) begin
      check($sformatf("pre_com_%0d", k), 32'(com), 32'h0);
      check($sformatf("pre_seg_%0d", k), 32'(seg), 32'h0);
      cyc(1);
    end
  endtask

  // Check one whole frame starting at a frame-start edge; ends at the next.
  task automatic run_frame(input logic [3:0][7:0] exp, input string tag);
    int fd = 0;
    for (int d = 0; d < 4; d++) begin
      check($sformatf("%s_com_d%0d", tag, d), 32'(com), 32'(4'b0001 << d));
      check($sformatf("%s_seg_d%0d", tag, d), 32'(seg), 32'(exp[d]));
      for (int k = 0; k < 4; k++) begin
        fd += int'(frame_done);
        cyc(1);
      end
    end
    check($sformatf("%s_frame_done_count", tag), fd, 1);
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; load = 1'b0; blank_lead = 1'b0;
    data_hex = '0; dp = '0; data1 = '0; dp1 = 1'b0;

    vecs[0] = '{16'h12AF, 4'b0100, 1'b0, {8'h60, 8'hDB, 8'hEE, 8'h8E}};
    vecs[1] = '{16'h0050, 4'b0000, 1'b1, {8'h00, 8'h00, 8'hB6, 8'hFC}};
    vecs[2] = '{16'h0000, 4'b0000, 1'b1, {8'h00, 8'h00, 8'h00, 8'hFC}};
    vecs[3] = '{16'h0000, 4'b0000, 1'b0, {8'hFC, 8'hFC, 8'hFC, 8'hFC}};
    vecs[4] = '{16'h0100, 4'b1111, 1'b1, {8'h01, 8'h61, 8'hFD, 8'hFD}};
    vecs[5] = '{16'h3E9C, 4'b1000, 1'b1, {8'hF3, 8'h9E, 8'hF6, 8'h9C}};
    vecs[6] = '{16'h7654, 4'b0000, 1'b0, {8'hE0, 8'hBE, 8'hB6, 8'h66}};
    vecs[7] = '{16'h0008, 4'b0010, 1'b1, {8'h00, 8'h00, 8'h01, 8'hFE}};

    // Reset state.
    cyc(2);
    check("rst_com", 32'(com), 32'h0);
    check("rst_seg", 32'(seg), 32'h0);
    check("rst_fd", 32'(frame_done), 32'h0);

    // Table-driven frames.
    for (int v = 0; v < 8; v++) begin
      start_run(vecs[v].hex, vecs[v].dp, vecs[v].blank);
      run_frame(vecs[v].seg, $sformatf("vec%0d", v));
    end

    // Mid-frame Load only shows from the next frame on.
    start_run(16'h2222, 4'b0000, 1'b0);
    run_frame({4{8'hDA}}, "sync_first");
    check("sync_d0", 32'(seg), 32'hDA);
    cyc(4);
    check("sync_d1", 32'(seg), 32'hDA);
    cyc(2);
    data_hex = 16'h1111; load = 1'b1;
    cyc(1);
    load = 1'b0;
    cyc(1);
    check("sync_d2_old", 32'(seg), 32'hDA);
    cyc(4);
    check("sync_d3_old", 32'(seg), 32'hDA);
    cyc(4);
    run_frame({4{8'h60}}, "sync_new");

    // Load in the cycle of the frame-start tick lands one frame late.
    cyc(15);
    data_hex = 16'h3333; load = 1'b1;
    cyc(1);
    load = 1'b0;
    check("coinc_com", 32'(com), 32'h1);
    check("coinc_seg_old", 32'(seg), 32'h60);
    cyc(16);
    check("coinc_com_late", 32'(com), 32'h1);
    check("coinc_seg_new", 32'(seg), 32'hF2);

    // EN dropped during digit 2, then re-raised.
    cyc(8);
    check("en_d2_com", 32'(com), 32'h4);
    cyc(1);
    en = 1'b0;
    cyc(1);
    check("en_off_com", 32'(com), 32'h0);
    check("en_off_seg", 32'(seg), 32'h0);
    cyc(5);
    check("en_off_com_hold", 32'(com), 32'h0);
    check("en_off_fd", 32'(frame_done), 32'h0);
    en = 1'b1;
    cyc(3);
    check("en_on_com_early", 32'(com), 32'h0);
    cyc(1);
    check("en_on_com", 32'(com), 32'h1);
    check("en_on_seg", 32'(seg), 32'hF2);

    // Reset mid-slot with a simultaneous Load: everything clears.
    cyc(2);
    rst = 1'b1; data_hex = 16'h4444; load = 1'b1;
    cyc(1);
    check("rst_mid_com", 32'(com), 32'h0);
    check("rst_mid_seg", 32'(seg), 32'h0);
    check("rst_mid_fd", 32'(frame_done), 32'h0);
    rst = 1'b0; load = 1'b0; blank_lead = 1'b0;
    cyc(3);
    check("rst_rel_com_early", 32'(com), 32'h0);
    cyc(1);
    check("rst_rel_com", 32'(com), 32'h1);
    check("rst_rel_seg_d0", 32'(seg), 32'hFC);
    cyc(4);
    check("rst_rel_seg_d1", 32'(seg), 32'hFC);

    // Single-digit instance with the shortest slot.
    rst = 1'b1; en = 1'b0;
    cyc(2);
    rst = 1'b0; en = 1'b1; data1 = 4'h5; dp1 = 1'b0; load = 1'b1;
    cyc(1);
    load = 1'b0;
    check("d1_pre_com", 32'(com1), 32'h0);
    check("d1_pre_fd", 32'(frame_done1), 32'h0);
    cyc(1);
    check("d1_com", 32'(com1), 32'h1);
    check("d1_seg", 32'(seg1), 32'hB6);
    check("d1_fd_first", 32'(frame_done1), 32'h1);
    for (int k = 0; k < 6; k++) begin
      cyc(1);
      check($sformatf("d1_com_%0d", k), 32'(com1), 32'h1);
      check($sformatf("d1_fd_%0d", k), 32'(frame_done1), 32'((k % 2) == 1));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
